// File: rtl/lagarto_dcache_port_arbiter.sv
// Shares the L1 dcache request port between the load (0) and store (1) channels; one op in flight, round-robin.
// Optional perf counters are enabled with `define LAGARTO_DCACHE_ARB_PERF_EN.
module lagarto_dcache_port_arbiter #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44,
    parameter int CNT_W   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_valid_i,
    input  logic [2*INDEX_W-1:0]   req_index_i,
    input  logic [127:0]           req_wdata_i,
    input  logic [15:0]            req_be_i,
    input  logic [3:0]             req_size_i,
    input  logic [1:0]             tag_valid_i,
    input  logic [2*TAG_W-1:0]     tag_i,
    input  logic [1:0]             kill_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [63:0]            rdata_o,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [INDEX_W-1:0]     addr_index_o,
    output logic                   we_o,
    output logic [63:0]            wdata_o,
    output logic [7:0]             be_o,
    output logic [1:0]             size_o,
    output logic                   tag_valid_o,
    output logic [TAG_W-1:0]       addr_tag_o,
    output logic                   kill_o,
    input  logic                   rvalid_i,
    input  logic [63:0]            rdata_i,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       conflict_cnt_o,
    output logic [CNT_W-1:0]       ld_wait_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IDX   = 3'd1,
        S_TAG   = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner;
    logic                 r_rr;
    logic [INDEX_W-1:0]   r_index;
    logic [63:0]          r_wdata;
    logic [7:0]           r_be;
    logic [1:0]           r_size;

    logic                 w_win;
    logic                 w_take;
    logic                 w_kill_own;
    logic                 w_tv_own;

    // r_rr names the channel that wins a tie, i.e. the one not served last
    assign w_win      = (&req_valid_i) ? r_rr : req_valid_i[1];
    assign w_take     = (r_state == S_IDLE) && (|req_valid_i);
    assign w_kill_own = r_owner ? kill_i[1] : kill_i[0];
    assign w_tv_own   = r_owner ? tag_valid_i[1] : tag_valid_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_index <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_owner <= w_win;
                r_index <= w_win ? req_index_i[2*INDEX_W-1:INDEX_W] : req_index_i[INDEX_W-1:0];
                r_wdata <= w_win ? req_wdata_i[127:64] : req_wdata_i[63:0];
                r_be    <= w_win ? req_be_i[15:8] : req_be_i[7:0];
                r_size  <= w_win ? req_size_i[3:2] : req_size_i[1:0];
            end
            if ((r_state == S_IDX) && gnt_i) begin
                r_rr <= ~r_owner;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        req_o       = 1'b0;
        tag_valid_o = 1'b0;
        addr_tag_o  = '0;
        kill_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid_i) begin
                    w_next = S_IDX;
                end
            end
            S_IDX: begin
                req_o = 1'b1;
                // A grant in the same cycle as a kill wins: the cache already took the index
                if (gnt_i) begin
                    gnt_o  = r_owner ? 2'b10 : 2'b01;
                    w_next = S_TAG;
                end else if (w_kill_own) begin
                    w_next = S_IDLE;
                end
            end
            S_TAG: begin
                addr_tag_o = r_owner ? tag_i[2*TAG_W-1:TAG_W] : tag_i[TAG_W-1:0];
                if (w_kill_own) begin
                    kill_o = 1'b1;
                    w_next = S_IDLE;
                end else if (w_tv_own) begin
                    tag_valid_o = 1'b1;
                    w_next      = r_owner ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (rvalid_i) begin
                    rvalid_o = kill_i[0] ? 2'b00 : 2'b01;
                    w_next   = S_IDLE;
                end else if (kill_i[0]) begin
                    kill_o = 1'b1;
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rvalid_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign rdata_o      = rdata_i;
    assign addr_index_o = r_index;
    assign we_o         = r_owner;
    assign wdata_o      = r_wdata;
    assign be_o         = r_be;
    assign size_o       = r_size;
    assign busy_o       = (r_state != S_IDLE);

`ifdef LAGARTO_DCACHE_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] r_conflict_cnt;
    logic [CNT_W-1:0] r_ld_wait_cnt;
    logic             w_conflict;
    logic             w_ld_wait;

    assign w_conflict = (r_state == S_IDLE) && (&req_valid_i);
    assign w_ld_wait  = req_valid_i[0] && !gnt_o[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_conflict_cnt <= '0;
            r_ld_wait_cnt  <= '0;
        end else begin
            if (w_conflict && !(&r_conflict_cnt)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
            end
            if (w_ld_wait && !(&r_ld_wait_cnt)) begin
                r_ld_wait_cnt <= r_ld_wait_cnt + CNT_ONE;
            end
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign ld_wait_cnt_o  = r_ld_wait_cnt;
`else
    assign conflict_cnt_o = '0;
    assign ld_wait_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_lagarto_dcache_port_arbiter.sv
// Directed bench for lagarto_dcache_port_arbiter: protocol phases, round-robin, kills, reset and perf counters.
module tb_lagarto_dcache_port_arbiter;

    localparam int INDEX_W = 12;
    localparam int TAG_W   = 44;
    localparam int CNT_W   = 32;
`ifdef LAGARTO_DCACHE_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk_i;
    logic                 rst_i;
    logic [1:0]           req_valid_i;
    logic [2*INDEX_W-1:0] req_index_i;
    logic [127:0]         req_wdata_i;
    logic [15:0]          req_be_i;
    logic [3:0]           req_size_i;
    logic [1:0]           tag_valid_i;
    logic [2*TAG_W-1:0]   tag_i;
    logic [1:0]           kill_i;
    logic [1:0]           gnt_o;
    logic [1:0]           rvalid_o;
    logic [63:0]          rdata_o;
    logic                 req_o;
    logic                 gnt_i;
    logic [INDEX_W-1:0]   addr_index_o;
    logic                 we_o;
    logic [63:0]          wdata_o;
    logic [7:0]           be_o;
    logic [1:0]           size_o;
    logic                 tag_valid_o;
    logic [TAG_W-1:0]     addr_tag_o;
    logic                 kill_o;
    logic                 rvalid_i;
    logic [63:0]          rdata_i;
    logic                 busy_o;
    logic [CNT_W-1:0]     conflict_cnt_o;
    logic [CNT_W-1:0]     ld_wait_cnt_o;

    int total = 0;
    int bad   = 0;

    lagarto_dcache_port_arbiter #(
        .INDEX_W(INDEX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_index_i(req_index_i), .req_wdata_i(req_wdata_i),
        .req_be_i(req_be_i), .req_size_i(req_size_i), .tag_valid_i(tag_valid_i),
        .tag_i(tag_i), .kill_i(kill_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .req_o(req_o), .gnt_i(gnt_i), .addr_index_o(addr_index_o),
        .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
        .tag_valid_o(tag_valid_o), .addr_tag_o(addr_tag_o), .kill_o(kill_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .busy_o(busy_o),
        .conflict_cnt_o(conflict_cnt_o), .ld_wait_cnt_o(ld_wait_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #3;
        smp();
        chk("rst_busy", busy_o, 0);
        chk("rst_req", req_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_kill", kill_o, 0);
        chk("rst_index", addr_index_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_ldwait", ld_wait_cnt_o, 0);
        chk("rst_conflict", conflict_cnt_o, 0);
        nxt();
        rst_i = 1'b0;
    endtask

    // Serves one op end to end; entered at the start of an IDLE cycle with req_valid_i already set
    task automatic serve(input int ch);
        smp();
        chk("srv_idle", busy_o, 0);
        nxt();
        gnt_i = 1'b1;
        smp();
        chk("srv_gnt", gnt_o, (ch == 1) ? 2 : 1);
        chk("srv_we", we_o, ch);
        nxt();
        gnt_i = 1'b0;
        req_valid_i[ch] = 1'b0;
        tag_valid_i = (ch == 1) ? 2'b10 : 2'b01;
        smp();
        chk("srv_tagv", tag_valid_o, 1);
        nxt();
        tag_valid_i = 2'b00;
        if (ch == 0) begin
            rvalid_i = 1'b1;
            rdata_i  = 64'h0000_1111_2222_3333;
            smp();
            chk("srv_rvalid", rvalid_o, 2'b01);
            nxt();
            rvalid_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = '0; req_index_i = '0; req_wdata_i = '0;
        req_be_i = '0; req_size_i = '0; tag_valid_i = '0; tag_i = '0; kill_i = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        nxt();
        do_reset();

        // single load
        req_valid_i = 2'b01;
        req_index_i = {12'h000, 12'h123};
        smp();
        chk("t1_idle_req", req_o, 0);
        nxt();
        gnt_i = 1'b1;
        smp();
        chk("t1_req", req_o, 1);
        chk("t1_gnt", gnt_o, 2'b01);
        chk("t1_index", addr_index_o, 12'h123);
        chk("t1_we", we_o, 0);
        nxt();
        gnt_i = 1'b0; req_valid_i = 2'b00;
        tag_valid_i = 2'b01; tag_i = {44'h0, 44'h0123_4567_89A};
        smp();
        chk("t1_tagv", tag_valid_o, 1);
        chk("t1_tag", addr_tag_o, 44'h0123_4567_89A);
        chk("t1_gnt_pulse", gnt_o, 0);
        nxt();
        tag_valid_i = 2'b00;
        smp();
        chk("t1_resp_wait", rvalid_o, 0);
        chk("t1_busy", busy_o, 1);
        nxt();
        rvalid_i = 1'b1; rdata_i = 64'hDEAD_BEEF;
        smp();
        chk("t1_rvalid", rvalid_o, 2'b01);
        chk("t1_rdata", rdata_o, 64'hDEAD_BEEF);
        nxt();
        rvalid_i = 1'b0;
        smp();
        chk("t1_done", busy_o, 0);
        nxt();

        // round-robin from reset: load, store, load, store
        do_reset();
        req_valid_i = 2'b11;
        serve(0);
        serve(1);
        req_valid_i = 2'b11;
        serve(0);
        serve(1);

        // store with a delayed grant; inputs change under a held request
        req_index_i = {12'hABC, 12'h000};
        req_wdata_i = {64'hCAFE_F00D_1234_5678, 64'h0};
        req_be_i    = {8'hF0, 8'h00};
        req_size_i  = {2'd3, 2'd0};
        req_valid_i = 2'b10;
        smp();
        nxt();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_index_i = '0;
                req_wdata_i = '0;
            end
            smp();
            chk("t3_req", req_o, 1);
            chk("t3_index", addr_index_o, 12'hABC);
            chk("t3_wdata", wdata_o, 64'hCAFE_F00D_1234_5678);
            chk("t3_we", we_o, 1);
            chk("t3_nognt", gnt_o, 0);
            nxt();
        end
        gnt_i = 1'b1;
        smp();
        chk("t3_gnt", gnt_o, 2'b10);
        chk("t3_be", be_o, 8'hF0);
        chk("t3_size", size_o, 2'd3);
        nxt();
        gnt_i = 1'b0; req_valid_i = 2'b00;
        tag_valid_i = 2'b10; tag_i = {44'hABC_DEF0_1234, 44'h0};
        smp();
        chk("t3_tagv", tag_valid_o, 1);
        chk("t3_tag", addr_tag_o, 44'hABC_DEF0_1234);
        nxt();
        tag_valid_i = 2'b00;
        smp();
        chk("t3_idle", busy_o, 0);
        chk("t3_norvalid", rvalid_o, 0);
        nxt();

        // kill in the tag phase, then a stray response
        req_valid_i = 2'b01;
        smp();
        nxt();
        gnt_i = 1'b1;
        smp();
        chk("t4_gnt", gnt_o, 2'b01);
        nxt();
        gnt_i = 1'b0; req_valid_i = 2'b00;
        tag_valid_i = 2'b01; kill_i = 2'b01;
        smp();
        chk("t4_kill", kill_o, 1);
        chk("t4_tagv", tag_valid_o, 0);
        nxt();
        kill_i = 2'b00; tag_valid_i = 2'b00; rvalid_i = 1'b1;
        smp();
        chk("t4_idle", busy_o, 0);
        chk("t4_stray", rvalid_o, 0);
        nxt();
        rvalid_i = 1'b0;

        // kill in the index phase before any grant
        req_valid_i = 2'b01;
        smp();
        nxt();
        kill_i = 2'b01;
        smp();
        chk("tk_req", req_o, 1);
        chk("tk_nognt", gnt_o, 0);
        nxt();
        kill_i = 2'b00; req_valid_i = 2'b00;
        smp();
        chk("tk_reqdrop", req_o, 0);
        chk("tk_idle", busy_o, 0);
        nxt();

        // kill in RESP, response arrives three cycles later and is swallowed
        req_valid_i = 2'b01;
        smp();
        nxt();
        gnt_i = 1'b1;
        smp();
        nxt();
        gnt_i = 1'b0; req_valid_i = 2'b00; tag_valid_i = 2'b01;
        smp();
        nxt();
        tag_valid_i = 2'b00; kill_i = 2'b01;
        smp();
        chk("t5_kill", kill_o, 1);
        chk("t5_norvalid", rvalid_o, 0);
        nxt();
        kill_i = 2'b00;
        smp();
        chk("t5_killpulse", kill_o, 0);
        chk("t5_drain_busy", busy_o, 1);
        nxt();
        smp();
        nxt();
        rvalid_i = 1'b1;
        smp();
        chk("t5_swallow", rvalid_o, 0);
        chk("t5_busy_last", busy_o, 1);
        nxt();
        rvalid_i = 1'b0;
        smp();
        chk("t5_idle", busy_o, 0);
        nxt();

        // reset in the middle of an op
        req_valid_i = 2'b01;
        req_index_i = {12'h000, 12'h3C3};
        smp();
        nxt();
        req_valid_i = 2'b00;
        smp();
        chk("t7_inflight", req_o, 1);
        nxt();
        do_reset();

        // perf counters: dual request while a store waits for its grant
        req_valid_i = 2'b10;
        smp();
        nxt();
        req_valid_i = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) gnt_i = 1'b1;
            smp();
            if (i == 5) begin
                chk("t6_ldwait_mid", ld_wait_cnt_o, PERF ? 4 : 0);
                chk("t6_conflict_mid", conflict_cnt_o, 0);
            end
            if (i == 10) chk("t6_store_gnt", gnt_o, 2'b10);
            nxt();
        end
        gnt_i = 1'b0; tag_valid_i = 2'b10;
        smp();
        chk("t6_tagv", tag_valid_o, 1);
        nxt();
        tag_valid_i = 2'b00;
        smp();
        chk("t6_ldwait_idle", ld_wait_cnt_o, PERF ? 11 : 0);
        chk("t6_conflict_pre", conflict_cnt_o, 0);
        nxt();
        gnt_i = 1'b1;
        smp();
        chk("t6_load_gnt", gnt_o, 2'b01);
        chk("t6_ldwait_gnt", ld_wait_cnt_o, PERF ? 12 : 0);
        chk("t6_conflict", conflict_cnt_o, PERF ? 1 : 0);
        nxt();
        gnt_i = 1'b0; req_valid_i = 2'b10; tag_valid_i = 2'b01;
        smp();
        chk("t6_ldwait_hold", ld_wait_cnt_o, PERF ? 12 : 0);
        chk("t6_conflict_hold", conflict_cnt_o, PERF ? 1 : 0);
        nxt();
        tag_valid_i = 2'b00; rvalid_i = 1'b1;
        smp();
        chk("t6_rvalid", rvalid_o, 2'b01);
        nxt();
        rvalid_i = 1'b0; req_valid_i = 2'b00;
        repeat (2) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
